// File: rtl/julia_pkg.sv
// ---------------------------------------------------------------------------
// julia_pkg
// Shared definitions for the escape-time engine:
//   - default word width / fractional bits of the Q16.16 datapath
//   - Q-format ONE and FOUR constants
//   - well-known Julia constants (Q16.16) for the coordinate generator
//   - FSM state encoding of julia_iter_engine
// ---------------------------------------------------------------------------
package julia_pkg;

    localparam int W_DEF    = 32;
    localparam int FRAC_DEF = 16;

    localparam logic signed [W_DEF-1:0] Q_ONE  = 32'sh0001_0000;
    localparam logic signed [W_DEF-1:0] Q_FOUR = 32'sh0004_0000;

    // Complex constant in the default Q16.16 format.
    typedef struct packed {
        logic signed [W_DEF-1:0] re;
        logic signed [W_DEF-1:0] im;
    } cplx_t;

    // Classic Julia constants, rounded to nearest Q16.16.
    localparam cplx_t PRESET_A = '{re: -32'sd26214, im: 32'sd39322};   // (-0.4,    0.6)
    localparam cplx_t PRESET_B = '{re: -32'sd52429, im: 32'sd10224};   // (-0.8,    0.156)
    localparam cplx_t PRESET_C = '{re: -32'sd47638, im: 32'sd12380};   // (-0.7269, 0.1889)

    // FSM encoding, kept as plain constants for compatibility with older blocks.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/julia_iter_engine_fx_sq_mul.sv
// ---------------------------------------------------------------------------
// fx_sq_mul
// Signed W x W -> 2W full-precision multiplier (purely combinational).
// Ports:
//   a, b : signed W-bit operands
//   p    : signed 2W-bit exact product
// ---------------------------------------------------------------------------
module fx_sq_mul #(
    parameter int W = 32
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);

    // Both operands signed, so they are sign-extended to 2W before multiplying.
    assign p = a * b;

endmodule

// File: rtl/julia_iter_engine.sv
// ---------------------------------------------------------------------------
// julia_iter_engine
// Fixed-point escape-time engine: one pixel per request, one iteration per
// clock. mode selects Julia (z0 = coord, c = cx/cy) or Mandelbrot (z0 = 0,
// c = coord).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start, in_ready     : request handshake (accept on start && in_ready)
//   mode                : 0 = Julia, 1 = Mandelbrot
//   coord_x, coord_y    : signed pixel coordinate (Q(W-FRAC).FRAC)
//   cx, cy              : signed Julia constant (ignored in Mandelbrot mode)
//   flush               : synchronous abort back to IDLE, discards result
//   out_valid, out_ready: result handshake
//   iter_count          : iterations performed before escape, or MAX_ITER
//   escaped             : 1 = |z|^2 exceeded 4, 0 = reached MAX_ITER
// ---------------------------------------------------------------------------
module julia_iter_engine
    import julia_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int FRAC     = FRAC_DEF,
    parameter int ITER_W   = 9,
    parameter int MAX_ITER = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                in_ready,
    input  logic                mode,
    input  logic signed [W-1:0] coord_x,
    input  logic signed [W-1:0] coord_y,
    input  logic signed [W-1:0] cx,
    input  logic signed [W-1:0] cy,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ITER_W-1:0]   iter_count,
    output logic                escaped
);

    localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);
    // 4.0 in the 2*FRAC product format, one bit wider than the products so
    // the sum of two squares can never overflow.
    localparam logic [2*W:0]      ESC_LIM = (2*W+1)'(4) << (2*FRAC);

    logic [1:0]             state;
    logic signed [W-1:0]    zx, zy, c_re, c_im;
    logic [ITER_W-1:0]      count;

    logic signed [2*W-1:0]  p_xx, p_yy, p_xy;
    logic [2*W:0]           mag;
    logic                   esc;
    logic signed [W-1:0]    zx_next, zy_next;

    fx_sq_mul #(.W(W)) u_mul_xx (.a(zx), .b(zx), .p(p_xx));
    fx_sq_mul #(.W(W)) u_mul_yy (.a(zy), .b(zy), .p(p_yy));
    fx_sq_mul #(.W(W)) u_mul_xy (.a(zx), .b(zy), .p(p_xy));

    // NOTE: every output of this block is assigned on every pass, so no latch
    // can be inferred.
    always_comb begin
        // Squares are non-negative: sign-extend by one bit and add unsigned.
        mag     = {p_xx[2*W-1], p_xx} + {p_yy[2*W-1], p_yy};
        esc     = mag > ESC_LIM;
        // Arithmetic shift back to FRAC bits, then wrap to W bits.
        zx_next = W'((p_xx - p_yy) >>> FRAC) + c_re;
        // Doubling is a shift; the lost MSB lies above the bits that survive.
        zy_next = W'((p_xy <<< 1) >>> FRAC) + c_im;
    end

    assign in_ready = (state == ST_IDLE);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values; the async reset also clears datapath
    // registers so a fresh request never sees stale z/c.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            zx         <= '0;
            zy         <= '0;
            c_re       <= '0;
            c_im       <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            iter_count <= '0;
            escaped    <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_ITER;
                        count <= '0;
                        if (mode) begin
                            zx   <= '0;
                            zy   <= '0;
                            c_re <= coord_x;
                            c_im <= coord_y;
                        end else begin
                            zx   <= coord_x;
                            zy   <= coord_y;
                            c_re <= cx;
                            c_im <= cy;
                        end
                    end
                end
                ST_ITER: begin
                    if (esc) begin
                        state      <= ST_DONE;
                        out_valid  <= 1'b1;
                        iter_count <= count;
                        escaped    <= 1'b1;
                    end else if (count == MAX_CNT) begin
                        state      <= ST_DONE;
                        out_valid  <= 1'b1;
                        iter_count <= MAX_CNT;
                        escaped    <= 1'b0;
                    end else begin
                        zx    <= zx_next;
                        zy    <= zy_next;
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_julia_iter_engine.sv
// ---------------------------------------------------------------------------
// tb_julia_iter_engine
// Scoreboarded bench for julia_iter_engine (default Q16.16, MAX_ITER = 256).
// A driver issues requests and pushes expected results; a monitor pops and
// compares whenever a result is handed off. Expected values come from a
// straightforward complex-iteration reference model.
// ---------------------------------------------------------------------------
module tb_julia_iter_engine;
    import julia_pkg::*;

    localparam int MAX_ITER = 256;

    typedef struct {
        int cnt;
        bit esc;
        int acc;   // index of the accept edge
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               in_ready;
    logic               mode;
    logic signed [31:0] coord_x, coord_y, cx, cy;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [8:0]         iter_count;
    logic               escaped;

    julia_iter_engine dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_ready   (in_ready),
        .mode       (mode),
        .coord_x    (coord_x),
        .coord_y    (coord_y),
        .cx         (cx),
        .cy         (cy),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .iter_count (iter_count),
        .escaped    (escaped)
    );

    always #5 clk = ~clk;

    int   cycle = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   rand_bp = 1'b0;
    exp_t sb[$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: iterate z <- z^2 + c on Q16.16 integers, escape when
    // |z|^2 > 4 (strict), cap at MAX_ITER.
    function automatic void ref_model(input bit m, input int x, input int y,
                                      input int c_r, input int c_i,
                                      output int cnt, output bit esc);
        int zr, zi, kr, ki;
        longint xx, yy, xy;
        longint unsigned mag;
        if (m) begin zr = 0; zi = 0; kr = x;   ki = y;   end
        else   begin zr = x; zi = y; kr = c_r; ki = c_i; end
        cnt = MAX_ITER;
        esc = 1'b0;
        for (int n = 0; n <= MAX_ITER; n++) begin
            xx  = longint'(zr) * longint'(zr);
            yy  = longint'(zi) * longint'(zi);
            xy  = longint'(zr) * longint'(zi);
            mag = longint'(xx) + longint'(yy);
            if (mag > (64'd4 << 32)) begin
                cnt = n;
                esc = 1'b1;
                return;
            end
            if (n == MAX_ITER) return;
            zr = int'((xx - yy) >>> 16) + kr;
            zi = int'(xy >>> 15) + ki;       // 2*xy / 2^16
        end
    endfunction

    task automatic scramble_inputs();
        mode    = 1'($urandom);
        coord_x = $urandom;
        coord_y = $urandom;
        cx      = $urandom;
        cy      = $urandom;
    endtask

    // Issue one request; when push is set, expect result e (acc is filled in).
    task automatic issue(input bit m, input int x, input int y, input int c_r,
                         input int c_i, input bit push, input exp_t e);
        int guard = 0;
        while (!in_ready) begin
            @(negedge clk);
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
            guard++;
            if (guard > 2000) begin
                check("issue_timeout", 64'd1, 64'd0);
                return;
            end
        end
        start   = 1'b1;
        mode    = m;
        coord_x = x;
        coord_y = y;
        cx      = c_r;
        cy      = c_i;
        if (push) begin
            e.acc = cycle + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();   // request must already be latched
    endtask

    task automatic issue_model(input bit m, input int x, input int y,
                               input int c_r, input int c_i);
        exp_t e;
        ref_model(m, x, y, c_r, c_i, e.cnt, e.esc);
        e.acc = 0;
        issue(m, x, y, c_r, c_i, 1'b1, e);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 || !in_ready) begin
            @(negedge clk);
            out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
            guard++;
            if (guard > 2000) begin
                check("drain_timeout", 64'(sb.size()), 64'd0);
                return;
            end
        end
    endtask

    task automatic wait_valid();
        int guard = 0;
        while (!out_valid) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                check("valid_timeout", 64'd0, 64'd1);
                return;
            end
        end
    endtask

    // Monitor: samples 2 time units after the falling edge, when both DUT
    // outputs and driver inputs are settled.
    initial begin
        bit   seen = 1'b0;
        int   rise = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                seen = 1'b0;
            end else begin
                if (out_valid && !seen) begin
                    seen = 1'b1;
                    rise = cycle;
                end
                if (!out_valid) seen = 1'b0;
                if (out_valid && out_ready && !flush) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 64'(out_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("iter_count", 64'(iter_count), 64'(e.cnt));
                        check("escaped", 64'(escaped), 64'(e.esc));
                        check("latency", 64'(rise - e.acc), 64'(e.cnt + 1));
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   x, y, c_r, c_i, held_cnt;
        bit   held_esc;
        rst       = 1'b1;
        start     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        mode      = 1'b0;
        coord_x   = '0;
        coord_y   = '0;
        cx        = '0;
        cy        = '0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_iter_count", 64'(iter_count), 64'd0);
        check("rst_escaped", 64'(escaped), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Origin never escapes: 256 iterations, 257-cycle latency
        e = '{cnt: 256, esc: 1'b0, acc: 0};
        issue(1'b0, 0, 0, 0, 0, 1'b1, e);
        drain();

        // Immediate escape at 2.5
        e = '{cnt: 0, esc: 1'b1, acc: 0};
        issue(1'b0, 32'h0002_8000, 0, 0, 0, 1'b1, e);
        drain();

        // Mandelbrot c = 1: |z|^2 = 4.0 exactly must not escape
        e = '{cnt: 3, esc: 1'b1, acc: 0};
        issue(1'b1, 32'h0001_0000, 0, 0, 0, 1'b1, e);
        drain();

        // Julia z0 = 2, c = -2: stuck at |z|^2 == 4 forever
        e = '{cnt: 256, esc: 1'b0, acc: 0};
        issue(1'b0, 32'h0002_0000, 0, -32'sh0002_0000, 0, 1'b1, e);
        drain();

        // Backpressure: result held for 10 cycles, start ignored
        out_ready = 1'b0;
        ref_model(1'b1, 32'h0000_8000, 32'h0000_4000, 0, 0, held_cnt, held_esc);
        e = '{cnt: held_cnt, esc: held_esc, acc: 0};
        issue(1'b1, 32'h0000_8000, 32'h0000_4000, 0, 0, 1'b1, e);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_iter_count", 64'(iter_count), 64'(held_cnt));
            check("bp_escaped", 64'(escaped), 64'(held_esc));
            check("bp_in_ready", 64'(in_ready), 64'd0);
            start   = i[0];
            coord_x = 32'h0002_8000;
            @(negedge clk);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_valid", 64'(out_valid), 64'd0);

        // Async reset mid-ITER (count = 50), result discarded
        issue(1'b0, 0, 0, 0, 0, 1'b0, e);
        repeat (50) @(negedge clk);
        check("iter_busy", 64'(in_ready), 64'd0);
        #1 rst = 1'b1;
        #1;
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check("async_rst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue_model(1'b0, 32'h0000_8000, 32'h0000_8000, PRESET_A.re, PRESET_A.im);
        drain();

        // flush in DONE alongside out_ready: result discarded
        out_ready = 1'b0;
        issue(1'b0, 32'h0002_8000, 0, 0, 0, 1'b0, e);
        wait_valid();
        out_ready = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_valid", 64'(out_valid), 64'd0);
        check("flush_done_in_ready", 64'(in_ready), 64'd1);

        // flush together with start in IDLE: request not accepted
        start   = 1'b1;
        flush   = 1'b1;
        mode    = 1'b0;
        coord_x = 32'h0002_8000;
        coord_y = 0;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("flush_start_no_result", 64'(out_valid), 64'd0);

        // Randomized requests with random backpressure
        rand_bp = 1'b1;
        for (int k = 0; k < 24; k++) begin
            x = int'($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000;
            y = int'($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000;
            case ($urandom_range(0, 3))
                0:       begin c_r = PRESET_A.re; c_i = PRESET_A.im; end
                1:       begin c_r = PRESET_B.re; c_i = PRESET_B.im; end
                2:       begin c_r = PRESET_C.re; c_i = PRESET_C.im; end
                default: begin
                    c_r = int'($urandom_range(0, 32'h0002_0000)) - 32'sh0001_0000;
                    c_i = int'($urandom_range(0, 32'h0002_0000)) - 32'sh0001_0000;
                end
            endcase
            issue_model(1'($urandom), x, y, c_r, c_i);
        end
        drain();
        rand_bp = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
